mandelbrot_iter_ctrl: RTL

- Sequences one `mandelbrot_alu` instance through the escape-time iteration for a single pixel.
- Accepts a pixel constant c=(cr,ci) and an iteration limit over a valid/ready handshake.
- Pulses the ALU once per iteration and feeds each z result back in as the next input.
- Stops on escape (`size` or `overflow`) or on reaching the limit, then returns the iteration count over a second valid/ready handshake.

---
 rtl/mandelbrot_pkg.sv | 18 +
 rtl/mandelbrot_period_check.sv | 40 ++++
 rtl/mandelbrot_iter_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot escape-time iteration controller:
// default widths, FSM state encoding and the fixed-point constant ONE.
package mandelbrot_pkg;

  localparam int unsigned WIDTH_DEF      = 8;
  localparam int unsigned ITER_WIDTH_DEF = 8;

  // 1.0 in signed 2.(WIDTH-2) fixed point
  localparam int unsigned ONE = 32'(1) << (WIDTH_DEF - 2);

  localparam int unsigned STATE_WIDTH = 2;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_WIDTH-1:0] ST_START = 2'd1;
  localparam logic [STATE_WIDTH-1:0] ST_WAIT  = 2'd2;
  localparam logic [STATE_WIDTH-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mandelbrot_period_check.sv
// Periodicity detector: keeps a z snapshot refreshed at power-of-two iteration
// counts and flags when a new ALU result repeats it (orbit is cyclic).
module mandelbrot_period_check
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ITER_WIDTH = ITER_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  update,
  input  logic [ITER_WIDTH-1:0] iter_n,
  input  logic [WIDTH-1:0]      res_zr,
  input  logic [WIDTH-1:0]      res_zi,
  output logic                  match_c
);

  logic [WIDTH-1:0] snap_zr_q;
  logic [WIDTH-1:0] snap_zi_q;
  logic             pow2_c;

  assign pow2_c  = (iter_n != '0) && ((iter_n & (iter_n - ITER_WIDTH'(1))) == '0);
  assign match_c = (res_zr == snap_zr_q) && (res_zi == snap_zi_q);

  // Snapshot starts at z0 = 0 and only moves on a non-matching power-of-two step
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_zr_q <= '0;
      snap_zi_q <= '0;
    end else if (clear) begin
      snap_zr_q <= '0;
      snap_zi_q <= '0;
    end else if (update && !match_c && pow2_c) begin
      snap_zr_q <= res_zr;
      snap_zi_q <= res_zi;
    end
  end

endmodule

// File: rtl/mandelbrot_iter_ctrl.sv
// Escape-time iteration controller: runs one mandelbrot_alu per pixel until
// escape or the iteration limit. MANDEL_PERIOD_CHECK_EN adds periodicity exit.
module mandelbrot_iter_ctrl
  import mandelbrot_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ITER_WIDTH = ITER_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_cr,
  input  logic [WIDTH-1:0]      in_ci,
  input  logic [ITER_WIDTH-1:0] in_max_iter,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ITER_WIDTH-1:0] out_iter,
  output logic                  out_escaped,
  output logic                  alu_start,
  input  logic                  alu_finished,
  output logic [WIDTH-1:0]      alu_cr,
  output logic [WIDTH-1:0]      alu_ci,
  output logic [WIDTH-1:0]      alu_zr,
  output logic [WIDTH-1:0]      alu_zi,
  input  logic [WIDTH-1:0]      alu_res_zr,
  input  logic [WIDTH-1:0]      alu_res_zi,
  input  logic                  alu_size,
  input  logic                  alu_overflow
);

  logic [STATE_WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0]       cr_q, cr_d;
  logic [WIDTH-1:0]       ci_q, ci_d;
  logic [WIDTH-1:0]       zr_q, zr_d;
  logic [WIDTH-1:0]       zi_q, zi_d;
  logic [ITER_WIDTH-1:0]  max_q, max_d;
  logic [ITER_WIDTH-1:0]  iter_q, iter_d;
  logic [ITER_WIDTH-1:0]  out_iter_q, out_iter_d;
  logic                   out_escaped_q, out_escaped_d;
  logic                   blank_q, blank_d;
  logic                   in_ready_q;
  logic                   alu_start_q;
  logic                   out_valid_q;

  logic                   accept_c;
  logic                   complete_c;
  logic                   escape_c;
  logic                   period_hit_c;
  logic [ITER_WIDTH-1:0]  iter_n_c;

  assign accept_c   = in_valid && in_ready_q;
  // First WAIT cycle is blanked: alu_finished may still show the previous run
  assign complete_c = (state_q == ST_WAIT) && !blank_q && alu_finished;
  assign escape_c   = alu_size || alu_overflow;
  assign iter_n_c   = iter_q + ITER_WIDTH'(1);

`ifdef MANDEL_PERIOD_CHECK_EN
  mandelbrot_period_check #(
    .WIDTH      (WIDTH),
    .ITER_WIDTH (ITER_WIDTH)
  ) u_period_check (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_c),
    .update  (complete_c && !escape_c),
    .iter_n  (iter_n_c),
    .res_zr  (alu_res_zr),
    .res_zi  (alu_res_zi),
    .match_c (period_hit_c)
  );
`else
  assign period_hit_c = 1'b0;
`endif

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    cr_d          = cr_q;
    ci_d          = ci_q;
    zr_d          = zr_q;
    zi_d          = zi_q;
    max_d         = max_q;
    iter_d        = iter_q;
    out_iter_d    = out_iter_q;
    out_escaped_d = out_escaped_q;
    blank_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          cr_d   = in_cr;
          ci_d   = in_ci;
          max_d  = in_max_iter;
          zr_d   = '0;
          zi_d   = '0;
          iter_d = '0;
          if (in_max_iter == '0) begin
            out_iter_d    = '0;
            out_escaped_d = 1'b0;
            state_d       = ST_DONE;
          end else begin
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        blank_d = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (complete_c) begin
          // Escape outranks both the periodicity exit and the limit
          if (escape_c) begin
            out_iter_d    = iter_n_c;
            out_escaped_d = 1'b1;
            state_d       = ST_DONE;
          end else if (period_hit_c || (iter_n_c == max_q)) begin
            out_iter_d    = max_q;
            out_escaped_d = 1'b0;
            state_d       = ST_DONE;
          end else begin
            zr_d    = alu_res_zr;
            zi_d    = alu_res_zi;
            iter_d  = iter_n_c;
            state_d = ST_START;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cr_q          <= '0;
      ci_q          <= '0;
      zr_q          <= '0;
      zi_q          <= '0;
      max_q         <= '0;
      iter_q        <= '0;
      out_iter_q    <= '0;
      out_escaped_q <= 1'b0;
      blank_q       <= 1'b0;
      in_ready_q    <= 1'b1;
      alu_start_q   <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cr_q          <= cr_d;
      ci_q          <= ci_d;
      zr_q          <= zr_d;
      zi_q          <= zi_d;
      max_q         <= max_d;
      iter_q        <= iter_d;
      out_iter_q    <= out_iter_d;
      out_escaped_q <= out_escaped_d;
      blank_q       <= blank_d;
      in_ready_q    <= (state_d == ST_IDLE);
      alu_start_q   <= (state_d == ST_START);
      out_valid_q   <= (state_d == ST_DONE);
    end
  end

  assign in_ready    = in_ready_q;
  assign alu_start   = alu_start_q;
  assign out_valid   = out_valid_q;
  assign out_iter    = out_iter_q;
  assign out_escaped = out_escaped_q;
  assign alu_cr      = cr_q;
  assign alu_ci      = ci_q;
  assign alu_zr      = zr_q;
  assign alu_zi      = zi_q;

endmodule
